// File: rtl/arbitro_saldo_pkg.sv
// Shared types and constants for the shared-balance arbiter.
package arbitro_saldo_pkg;

   localparam int unsigned ANCHO_SALDO_DEF = 64;
   localparam int unsigned ANCHO_MONTO_DEF = 32;

   // Request type encoding as seen on tipo_0 / tipo_1.
   localparam logic DEPOSITO = 1'b0;
   localparam logic RETIRO   = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StCommit
   } estado_t;

endpackage

// File: rtl/selector_rr.sv
// Two-way round-robin pick: on a tie, the port that was not served last wins.
module selector_rr
   import arbitro_saldo_pkg::*;
(
   input  logic [1:0] pending,
   input  logic       ultimo,
   output logic       sel,
   output logic       valid
);

   // Pick the single pending port, or the one other than ultimo when both wait.
   always_comb begin
      valid = |pending;
      if (&pending) begin
         sel = ~ultimo;
      end else begin
         sel = pending[1];
      end
   end

endmodule

// File: rtl/arbitro_saldo.sv
// Shared-balance arbiter: two teller ports, round-robin grant, funds and
// overflow checking, atomic balance commit with per-port completion pulses.
module arbitro_saldo
   import arbitro_saldo_pkg::*;
#(
   parameter int unsigned ANCHO_SALDO = ANCHO_SALDO_DEF,
   parameter int unsigned ANCHO_MONTO = ANCHO_MONTO_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ANCHO_SALDO-1:0] balance_inicial,
   input  logic                   stb_0,
   input  logic                   stb_1,
   input  logic                   tipo_0,
   input  logic                   tipo_1,
   input  logic [ANCHO_MONTO-1:0] monto_0,
   input  logic [ANCHO_MONTO-1:0] monto_1,
   output logic                   busy_0,
   output logic                   busy_1,
   output logic                   done_0,
   output logic                   done_1,
   output logic                   ok_0,
   output logic                   ok_1,
   output logic                   fondos_insuf_0,
   output logic                   fondos_insuf_1,
   output logic [ANCHO_SALDO-1:0] balance,
   output logic                   balance_actualizado
);

   estado_t                estado_q, estado_d;
   logic [1:0]             pending_q, pending_d;
   logic [1:0]             tipo_q, tipo_d;
   logic [ANCHO_MONTO-1:0] monto0_q, monto0_d;
   logic [ANCHO_MONTO-1:0] monto1_q, monto1_d;
   logic                   ultimo_q, ultimo_d;
   logic                   sel_q, sel_d;
   logic                   res_ok_q, res_ok_d;
   logic                   res_insuf_q, res_insuf_d;
   logic [ANCHO_SALDO-1:0] nuevo_q, nuevo_d;
   logic [ANCHO_SALDO-1:0] balance_q, balance_d;
   logic [1:0]             done_q, done_d;
   logic [1:0]             ok_q, ok_d;
   logic [1:0]             insuf_q, insuf_d;
   logic                   act_q, act_d;
   logic [1:0]             clr_pend;

   logic                   rr_sel;
   logic                   rr_valid;
   logic                   tipo_sel;
   logic [ANCHO_MONTO-1:0] monto_sel;
   logic [ANCHO_SALDO-1:0] monto_ext;
   logic [ANCHO_SALDO:0]   suma;
   logic                   retiro_insuf;

   selector_rr u_selector_rr (
      .pending (pending_q),
      .ultimo  (ultimo_q),
      .sel     (rr_sel),
      .valid   (rr_valid)
   );

   // Operands of the selected slot; the extra sum bit catches balance overflow.
   always_comb begin
      tipo_sel     = tipo_q[sel_q];
      monto_sel    = sel_q ? monto1_q : monto0_q;
      monto_ext    = ANCHO_SALDO'(monto_sel);
      suma         = {1'b0, balance_q} + {1'b0, monto_ext};
      retiro_insuf = monto_ext > balance_q;
   end

   // Request capture: a strobe is taken only while its slot is free.
   always_comb begin
      pending_d = pending_q & ~clr_pend;
      tipo_d    = tipo_q;
      monto0_d  = monto0_q;
      monto1_d  = monto1_q;
      if (stb_0 && !pending_q[0]) begin
         pending_d[0] = 1'b1;
         tipo_d[0]    = tipo_0;
         monto0_d     = monto_0;
      end
      if (stb_1 && !pending_q[1]) begin
         pending_d[1] = 1'b1;
         tipo_d[1]    = tipo_1;
         monto1_d     = monto_1;
      end
   end

   // Result evaluation, registered during CHECK and consumed in COMMIT.
   always_comb begin
      res_ok_d    = res_ok_q;
      res_insuf_d = res_insuf_q;
      nuevo_d     = nuevo_q;
      if (estado_q == StCheck) begin
         if (tipo_sel == DEPOSITO) begin
            res_ok_d    = ~suma[ANCHO_SALDO];
            res_insuf_d = 1'b0;
            nuevo_d     = suma[ANCHO_SALDO-1:0];
         end else begin
            res_ok_d    = ~retiro_insuf;
            res_insuf_d = retiro_insuf;
            nuevo_d     = balance_q - monto_ext;
         end
      end
   end

   // FSM next state: grant in IDLE, then one cycle each for CHECK and COMMIT.
   always_comb begin
      estado_d = estado_q;
      sel_d    = sel_q;
      case (estado_q)
         StIdle: begin
            if (rr_valid) begin
               sel_d    = rr_sel;
               estado_d = StCheck;
            end
         end
         StCheck:  estado_d = StCommit;
         StCommit: estado_d = StIdle;
         default:  estado_d = StIdle;
      endcase
   end

   // FSM outputs: COMMIT applies the balance, pulses DONE and frees the slot.
   always_comb begin
      done_d    = '0;
      ok_d      = '0;
      insuf_d   = '0;
      act_d     = 1'b0;
      clr_pend  = '0;
      balance_d = balance_q;
      ultimo_d  = ultimo_q;
      if (estado_q == StCommit) begin
         done_d[sel_q]   = 1'b1;
         ok_d[sel_q]     = res_ok_q;
         insuf_d[sel_q]  = res_insuf_q;
         clr_pend[sel_q] = 1'b1;
         ultimo_d        = sel_q;
         if (res_ok_q) begin
            balance_d = nuevo_q;
            act_d     = 1'b1;
         end
      end
   end

   // State register; reset reloads the balance and drops any in-flight work.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q    <= StIdle;
         pending_q   <= '0;
         tipo_q      <= '0;
         monto0_q    <= '0;
         monto1_q    <= '0;
         ultimo_q    <= 1'b1;
         sel_q       <= 1'b0;
         res_ok_q    <= 1'b0;
         res_insuf_q <= 1'b0;
         nuevo_q     <= '0;
         balance_q   <= balance_inicial;
         done_q      <= '0;
         ok_q        <= '0;
         insuf_q     <= '0;
         act_q       <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         pending_q   <= pending_d;
         tipo_q      <= tipo_d;
         monto0_q    <= monto0_d;
         monto1_q    <= monto1_d;
         ultimo_q    <= ultimo_d;
         sel_q       <= sel_d;
         res_ok_q    <= res_ok_d;
         res_insuf_q <= res_insuf_d;
         nuevo_q     <= nuevo_d;
         balance_q   <= balance_d;
         done_q      <= done_d;
         ok_q        <= ok_d;
         insuf_q     <= insuf_d;
         act_q       <= act_d;
      end
   end

   assign busy_0              = pending_q[0];
   assign busy_1              = pending_q[1];
   assign done_0              = done_q[0];
   assign done_1              = done_q[1];
   assign ok_0                = ok_q[0];
   assign ok_1                = ok_q[1];
   assign fondos_insuf_0      = insuf_q[0];
   assign fondos_insuf_1      = insuf_q[1];
   assign balance             = balance_q;
   assign balance_actualizado = act_q;

endmodule

// File: tb/tb_arbitro_saldo.sv
// Self-checking bench for arbitro_saldo: scoreboard of expected completions.
module tb_arbitro_saldo;
   import arbitro_saldo_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] balance_inicial;
   logic        stb_0, stb_1, tipo_0, tipo_1;
   logic [31:0] monto_0, monto_1;
   logic        busy_0, busy_1, done_0, done_1, ok_0, ok_1;
   logic        fondos_insuf_0, fondos_insuf_1;
   logic [63:0] balance;
   logic        balance_actualizado;

   always #5 clk = ~clk;

   arbitro_saldo #(
      .ANCHO_SALDO (64),
      .ANCHO_MONTO (32)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .balance_inicial     (balance_inicial),
      .stb_0               (stb_0),
      .stb_1               (stb_1),
      .tipo_0              (tipo_0),
      .tipo_1              (tipo_1),
      .monto_0             (monto_0),
      .monto_1             (monto_1),
      .busy_0              (busy_0),
      .busy_1              (busy_1),
      .done_0              (done_0),
      .done_1              (done_1),
      .ok_0                (ok_0),
      .ok_1                (ok_1),
      .fondos_insuf_0      (fondos_insuf_0),
      .fondos_insuf_1      (fondos_insuf_1),
      .balance             (balance),
      .balance_actualizado (balance_actualizado)
   );

   typedef struct {
      logic        port;
      logic        ok;
      logic        insuf;
      logic [63:0] bal;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          errors  = 0;
   int          checks  = 0;
   int          cyc     = 0;
   int          act_cnt = 0;
   logic [63:0] model_bal;
   logic        model_ult;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference model: evaluates a transaction against the model balance.
   task automatic push_exp(input logic port, input logic tipo, input logic [31:0] monto,
                           input int when);
      exp_t        e;
      logic [64:0] s;
      e.port = port;
      e.cyc  = when;
      if (tipo == DEPOSITO) begin
         s       = {1'b0, model_bal} + 65'(monto);
         e.insuf = 1'b0;
         e.ok    = (s[64] == 1'b0);
         if (e.ok) model_bal = s[63:0];
      end else begin
         e.insuf = (64'(monto) > model_bal);
         e.ok    = !e.insuf;
         if (e.ok) model_bal = model_bal - 64'(monto);
      end
      e.bal     = model_bal;
      model_ult = port;
      sb.push_back(e);
   endtask

   task automatic drive(input logic s0, input logic t0, input logic [31:0] m0,
                        input logic s1, input logic t1, input logic [31:0] m1);
      stb_0   = s0;
      tipo_0  = t0;
      monto_0 = m0;
      stb_1   = s1;
      tipo_1  = t1;
      monto_1 = m1;
      tick();
      stb_0   = 1'b0;
      stb_1   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      exp_t e;
      int   n;
      logic a_ok, a_insuf, o_ok, o_insuf, a_busy;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         tick();
         n++;
         if (balance_actualizado) act_cnt++;
         checks++;
         if (done_0 && done_1) begin
            errors++;
            $display("FAIL two_done: done_0=%b done_1=%b, required at most one", done_0, done_1);
         end
         if (done_0 || done_1) begin
            e       = sb.pop_front();
            a_ok    = done_1 ? ok_1 : ok_0;
            a_insuf = done_1 ? fondos_insuf_1 : fondos_insuf_0;
            o_ok    = done_1 ? ok_0 : ok_1;
            o_insuf = done_1 ? fondos_insuf_0 : fondos_insuf_1;
            a_busy  = done_1 ? busy_1 : busy_0;
            checks++;
            if (done_1 !== e.port) begin
               errors++;
               $display("FAIL done_port: got port %0d, required %0d", done_1, e.port);
            end
            checks++;
            if (cyc !== e.cyc) begin
               errors++;
               $display("FAIL done_cycle: got cycle %0d, required %0d", cyc, e.cyc);
            end
            checks++;
            if (a_ok !== e.ok) begin
               errors++;
               $display("FAIL ok: got %b, required %b", a_ok, e.ok);
            end
            checks++;
            if (a_insuf !== e.insuf) begin
               errors++;
               $display("FAIL fondos_insuf: got %b, required %b", a_insuf, e.insuf);
            end
            checks++;
            if ({o_ok, o_insuf} !== 2'b00) begin
               errors++;
               $display("FAIL other_flags: got %b%b, required 00", o_ok, o_insuf);
            end
            checks++;
            if (balance !== e.bal) begin
               errors++;
               $display("FAIL balance: got %0d, required %0d", balance, e.bal);
            end
            checks++;
            if (balance_actualizado !== e.ok) begin
               errors++;
               $display("FAIL balance_actualizado: got %b, required %b", balance_actualizado,
                        e.ok);
            end
            checks++;
            if (a_busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_after_done: got %b, required 0", a_busy);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL done_timeout: %0d completions outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_quiet(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checks++;
         if ({done_0, done_1, balance_actualizado} !== 3'b000) begin
            errors++;
            $display("FAIL quiet: done=%b%b act=%b, required 000", done_1, done_0,
                     balance_actualizado);
         end
      end
   endtask

   task automatic do_reset(input logic [63:0] init);
      reset           = 1'b0;
      balance_inicial = init;
      stb_0           = 1'b0;
      stb_1           = 1'b0;
      tick();
      tick();
      reset     = 1'b1;
      model_bal = init;
      model_ult = 1'b1;
      act_cnt   = 0;
   endtask

   task automatic test_reset();
      reset           = 1'b0;
      balance_inicial = 64'd12345;
      stb_0           = 1'b1;
      stb_1           = 1'b1;
      tick();
      tick();
      checks++;
      if (balance !== 64'd12345) begin
         errors++;
         $display("FAIL reset_balance: got %0d, required 12345", balance);
      end
      checks++;
      if ({busy_0, busy_1, done_0, done_1, ok_0, ok_1, fondos_insuf_0, fondos_insuf_1,
           balance_actualizado} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b%b done=%b%b ok=%b%b insuf=%b%b act=%b, required 0",
                  busy_1, busy_0, done_1, done_0, ok_1, ok_0, fondos_insuf_1,
                  fondos_insuf_0, balance_actualizado);
      end
      stb_0 = 1'b0;
      stb_1 = 1'b0;
      do_reset(64'd0);
   endtask

   task automatic test_deposit();
      do_reset(64'd10000);
      push_exp(1'b0, DEPOSITO, 32'd10000, cyc + 4);
      drive(1'b1, DEPOSITO, 32'd10000, 1'b0, 1'b0, 32'd0);
      wait_done(10);
      check_quiet(2);
      checks++;
      if (act_cnt !== 1) begin
         errors++;
         $display("FAIL deposit_act_pulses: got %0d, required 1", act_cnt);
      end
      checks++;
      if (balance !== 64'd20000) begin
         errors++;
         $display("FAIL deposit_balance: got %0d, required 20000", balance);
      end
   endtask

   task automatic test_withdrawal();
      push_exp(1'b1, RETIRO, 32'd7000, cyc + 4);
      drive(1'b0, 1'b0, 32'd0, 1'b1, RETIRO, 32'd7000);
      wait_done(10);
      push_exp(1'b1, RETIRO, 32'd13000, cyc + 4);
      drive(1'b0, 1'b0, 32'd0, 1'b1, RETIRO, 32'd13000);
      wait_done(10);
      checks++;
      if (balance !== 64'd0) begin
         errors++;
         $display("FAIL withdraw_to_zero: got %0d, required 0", balance);
      end
   endtask

   task automatic test_insufficient();
      do_reset(64'd10000);
      push_exp(1'b0, RETIRO, 32'd900000, cyc + 4);
      drive(1'b1, RETIRO, 32'd900000, 1'b0, 1'b0, 32'd0);
      wait_done(10);
      check_quiet(2);
      checks++;
      if (act_cnt !== 0 || balance !== 64'd10000) begin
         errors++;
         $display("FAIL insuf_unchanged: act=%0d bal=%0d, required 0 and 10000", act_cnt,
                  balance);
      end
   endtask

   task automatic test_contention();
      logic first;
      do_reset(64'd10000);
      for (int r = 0; r < 2; r++) begin
         first = ~model_ult;
         if (first == 1'b0) begin
            push_exp(1'b0, DEPOSITO, 32'd100, cyc + 4);
            push_exp(1'b1, RETIRO, 32'd50, cyc + 7);
         end else begin
            push_exp(1'b1, RETIRO, 32'd50, cyc + 4);
            push_exp(1'b0, DEPOSITO, 32'd100, cyc + 7);
         end
         drive(1'b1, DEPOSITO, 32'd100, 1'b1, RETIRO, 32'd50);
         if (r == 0) begin
            // Extra deposit while port 0 is still pending must be dropped.
            stb_0   = 1'b1;
            tipo_0  = DEPOSITO;
            monto_0 = 32'd5000;
            tick();
            stb_0 = 1'b0;
         end
         wait_done(20);
      end
      check_quiet(3);
      checks++;
      if (balance !== 64'd10100) begin
         errors++;
         $display("FAIL contention_balance: got %0d, required 10100", balance);
      end
   endtask

   task automatic test_overflow();
      do_reset(64'hFFFF_FFFF_FFFF_FFFF);
      push_exp(1'b1, DEPOSITO, 32'd1, cyc + 4);
      drive(1'b0, 1'b0, 32'd0, 1'b1, DEPOSITO, 32'd1);
      wait_done(10);
      checks++;
      if (act_cnt !== 0 || balance !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL overflow_unchanged: act=%0d bal=%0h, required 0 and all ones", act_cnt,
                  balance);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset(64'd3000);
      drive(1'b1, DEPOSITO, 32'd500, 1'b1, RETIRO, 32'd100);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if ({busy_0, busy_1} !== 2'b00 || balance !== 64'd3000) begin
         errors++;
         $display("FAIL midreset_state: busy=%b%b bal=%0d, required 00 and 3000", busy_1,
                  busy_0, balance);
      end
      check_quiet(6);
      push_exp(1'b0, DEPOSITO, 32'd7, cyc + 4);
      drive(1'b1, DEPOSITO, 32'd7, 1'b0, 1'b0, 32'd0);
      wait_done(10);
   endtask

   task automatic test_back_to_back();
      do_reset(64'd1000);
      push_exp(1'b0, DEPOSITO, 32'd1, cyc + 4);
      drive(1'b1, DEPOSITO, 32'd1, 1'b0, 1'b0, 32'd0);
      wait_done(10);
      // Strobe sampled at the edge ending the DONE cycle is accepted.
      push_exp(1'b0, RETIRO, 32'd2, cyc + 4);
      drive(1'b1, RETIRO, 32'd2, 1'b0, 1'b0, 32'd0);
      wait_done(10);
   endtask

   initial begin
      stb_0           = 1'b0;
      stb_1           = 1'b0;
      tipo_0          = 1'b0;
      tipo_1          = 1'b0;
      monto_0         = '0;
      monto_1         = '0;
      reset           = 1'b0;
      balance_inicial = '0;
      model_bal       = '0;
      model_ult       = 1'b1;
      test_reset();
      test_deposit();
      test_withdrawal();
      test_insufficient();
      test_contention();
      test_overflow();
      test_reset_mid_op();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/arbitro_saldo.md
# arbitro_saldo

Shared-balance arbiter for the ATM datapath: two teller front-ends (ports 0 and 1) submit deposit and withdrawal requests against a single account balance register. The block latches each request, grants access round-robin, and checks funds and overflow. It commits the new balance atomically and returns a per-port completion pulse with the result. It sits between the per-terminal transaction controllers and the balance storage.

## Interface

- ANCHO_SALDO, 64, balance width
- ANCHO_MONTO, 32, request amount width

- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  reset, synchronous, active-low
- BALANCE_INICIAL  input  ANCHO_SALDO  value loaded into balance while RESET=0
- STB_0, STB_1  input  1  request strobe per port
- TIPO_0, TIPO_1  input  1  0 = deposit, 1 = withdrawal; sampled with STB
- MONTO_0, MONTO_1  input  ANCHO_MONTO  amount; sampled with STB
- BUSY_0, BUSY_1  output  1  port has a pending request; STB ignored while high
- DONE_0, DONE_1  output  1  one-cycle completion pulse
- OK_0, OK_1  output  1  transaction committed; valid while DONE high
- FONDOS_INSUF_0, FONDOS_INSUF_1  output  1  withdrawal rejected, amount > balance; valid while DONE high
- BALANCE  output  ANCHO_SALDO  current committed balance
- BALANCE_ACTUALIZADO  output  1  one-cycle pulse when BALANCE changes

## Operation

**Reset.** While RESET=0 at an edge, the following values are set:
- BALANCE = BALANCE_INICIAL.
- All pending slots are cleared.
- The FSM goes to IDLE.
- ULTIMO = 1, so port 0 wins the first tie.
- BUSY, DONE, OK, FONDOS_INSUF and BALANCE_ACTUALIZADO are all 0.

**Request capture.** STB_i=1 with BUSY_i=0 latches TIPO_i and MONTO_i into slot i and sets pending_i. BUSY_i equals pending_i. STB_i sampled while BUSY_i=1 is dropped silently.

**FSM (IDLE, CHECK, COMMIT):**
- **IDLE:** if no port is pending, stay. If exactly one is pending, select it. If both are pending, select the port ≠ ULTIMO. Then go to CHECK. A request captured at the same edge is not visible until the next cycle.
- **CHECK:** compute the result for the selected slot:
  - Deposit: sum = BALANCE + MONTO, in ANCHO_SALDO+1 bits. A carry-out means reject with OK=0 and FONDOS_INSUF=0.
  - Withdrawal: if MONTO > BALANCE, reject with FONDOS_INSUF=1 and OK=0. If MONTO ≤ BALANCE, accept; MONTO = BALANCE gives a balance of 0.
  - The result is registered, then the FSM goes to COMMIT.
- **COMMIT:**
  - On accept, BALANCE is updated and BALANCE_ACTUALIZADO pulses.
  - DONE_sel pulses with OK_sel and FONDOS_INSUF_sel.
  - pending_sel is cleared, ULTIMO = sel, and the FSM returns to IDLE.

**Other outputs.** The OK and FONDOS_INSUF flags of the non-selected port stay 0. Only one DONE is high in any cycle.

**Reset mid-operation.** An in-flight transaction is discarded: no DONE pulse and no balance change apart from the reload.

## Timing

- STB_i is sampled at edge E0, and pending_i is set after E0.
- With the FSM in IDLE and no contention:
  - CHECK after E1.
  - COMMIT after E2.
  - After E3: DONE_i, OK_i and FONDOS_INSUF_i are high for exactly one cycle, BALANCE holds the new value and BUSY_i=0.
- Throughput is one transaction per 3 cycles. A second pending port is selected at the IDLE edge immediately after its competitor's COMMIT.
- A new STB_i sampled in the cycle where DONE_i=1 is accepted.
- All outputs are registered; there is no combinational input-to-output path.

## Structure

- Shared package `arbitro_saldo_pkg` holds:
  - the state enum (IDLE, CHECK, COMMIT);
  - TIPO constants DEPOSITO=1'b0 and RETIRO=1'b1;
  - the default widths.
- One sub-module, `selector_rr`: a combinational 2-way round-robin pick. Inputs are pending[1:0] and ULTIMO; outputs are sel and valid.
- Balance arithmetic and the FSM live in the top module.

## Test plan

1. **Deposit:** BALANCE_INICIAL=10000, STB_0 deposit 10000 → DONE_0 three edges later with OK_0=1. BALANCE=20000 with a single BALANCE_ACTUALIZADO pulse.
2. **Withdrawal:** from 20000, STB_1 withdraw 7000 → DONE_1, OK_1=1, BALANCE=13000. Then withdraw 13000 → OK_1=1, BALANCE=0.
3. **Insufficient funds:** BALANCE=10000, STB_0 withdraw 900000 → DONE_0, OK_0=0, FONDOS_INSUF_0=1. BALANCE unchanged, no BALANCE_ACTUALIZADO pulse.
4. **Contention:** from 10000, the same-edge requests below are issued, then the pair is repeated.

   | Step | Expected response |
   |---|---|
   | STB_0 deposit 100 and STB_1 withdraw 50 at the same edge | DONE_0 at E3, DONE_1 at E6, final BALANCE=10050 |
   | Repeat the pair | Port 1 served first |
   | Extra STB_0 pulse while BUSY_0=1 | Ignored |
5. **Overflow:** BALANCE_INICIAL=2^64−1, deposit 1 → DONE with OK=0 and FONDOS_INSUF=0. BALANCE unchanged.
6. **Reset mid-operation:** RESET=0 for one cycle while in CHECK → no DONE pulse. BALANCE=BALANCE_INICIAL, BUSY_0=BUSY_1=0. A following request completes normally.
